// File: rtl/csr_req_arbiter.sv
// rtl/csr_req_arbiter.sv - round-robin arbiter sharing one CSR request/response port
module csr_req_arbiter #(
    parameter int NumReq       = 2,
    parameter int CsrDataWidth = 32,
    parameter int CsrAddrWidth = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0][CsrDataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0][CsrAddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0]                   req_write_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    output logic [NumReq-1:0][CsrDataWidth-1:0] rsp_data_o,
    output logic [NumReq-1:0]                   rsp_valid_o,
    input  logic [NumReq-1:0]                   rsp_ready_i,
    output logic [CsrDataWidth-1:0]             csr_req_data_o,
    output logic [CsrAddrWidth-1:0]             csr_req_addr_o,
    output logic                                csr_req_write_o,
    output logic                                csr_req_valid_o,
    input  logic                                csr_req_ready_i,
    input  logic [CsrDataWidth-1:0]             csr_rsp_data_i,
    input  logic                                csr_rsp_valid_i,
    output logic                                csr_rsp_ready_o,
    output logic                                busy_o,
    output logic                                err_o
);

    localparam int ReqIdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_RSP = 1'b1;

    logic [0:0]            state_q;
    logic [ReqIdWidth-1:0] rr_ptr_q;
    logic [ReqIdWidth-1:0] owner_q;
    logic                  lock_q;
    logic [ReqIdWidth-1:0] lock_id_q;
    logic                  err_q;

    logic [ReqIdWidth-1:0] rr_grant;
    logic [ReqIdWidth-1:0] grant;
    logic [ReqIdWidth-1:0] grant_next_ptr;
    logic [ReqIdWidth-1:0] idx;
    logic                  found;
    logic                  any_valid;
    logic                  accept;
    logic                  rsp_hs;

    assign any_valid = |req_valid_i;

    // First valid requester at or after rr_ptr_q, wrapping modulo NumReq.
    always_comb begin
        rr_grant = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = ReqIdWidth'((int'(rr_ptr_q) + k) % NumReq);
            if (!found && req_valid_i[idx]) begin
                found    = 1'b1;
                rr_grant = idx;
            end
        end
    end

    // A stalled grant is pinned so a later, higher-priority arrival cannot steal it.
    assign grant          = lock_q ? lock_id_q : rr_grant;
    assign grant_next_ptr = (grant == ReqIdWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
    assign accept         = (state_q == IDLE) && any_valid && csr_req_ready_i;
    assign rsp_hs         = (state_q == WAIT_RSP) && csr_rsp_valid_i && csr_rsp_ready_o;

    always_comb begin
        req_ready_o     = '0;
        rsp_data_o      = '0;
        rsp_valid_o     = '0;
        csr_req_data_o  = '0;
        csr_req_addr_o  = '0;
        csr_req_write_o = 1'b0;
        csr_req_valid_o = 1'b0;
        csr_rsp_ready_o = 1'b1;
        if (state_q == IDLE) begin
            if (any_valid) begin
                csr_req_valid_o    = 1'b1;
                csr_req_data_o     = req_data_i[grant];
                csr_req_addr_o     = req_addr_i[grant];
                csr_req_write_o    = req_write_i[grant];
                req_ready_o[grant] = csr_req_ready_i;
            end
        end else begin
            rsp_valid_o[owner_q] = csr_rsp_valid_i;
            rsp_data_o[owner_q]  = csr_rsp_data_i;
            csr_rsp_ready_o      = rsp_ready_i[owner_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (csr_rsp_valid_i) begin
                    err_q <= 1'b1;
                end
                if (accept) begin
                    rr_ptr_q <= grant_next_ptr;
                    lock_q   <= 1'b0;
                    if (!req_write_i[grant]) begin
                        owner_q <= grant;
                        state_q <= WAIT_RSP;
                    end
                end else if (any_valid) begin
                    lock_q    <= 1'b1;
                    lock_id_q <= grant;
                end else begin
                    lock_q <= 1'b0;
                end
            end else if (rsp_hs) begin
                state_q <= IDLE;
            end
        end
    end

    assign busy_o = (state_q == WAIT_RSP);
    assign err_o  = err_q;

endmodule

// File: doc/csr_req_arbiter.md
Name: csr_req_arbiter

Overview:
- Round-robin arbiter that lets NumReq requesters share the single CSR request/response port.
- Typical requesters: host bus bridge, debug port, instruction/seed preloader.
- Sits directly in front of the CSR bank.
- Tracks one outstanding read and routes its response back to the requester that issued it.

Parameters:
- NumReq, 2, number of requesters (>=2).
- CsrDataWidth, 32, CSR data width.
- CsrAddrWidth, 32, CSR address width.
- ReqIdWidth, $clog2(NumReq), derived, do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_data_i  in  NumReq x CsrDataWidth  per-requester write data
- req_addr_i  in  NumReq x CsrAddrWidth  per-requester address
- req_write_i  in  NumReq  1=write, 0=read
- req_valid_i  in  NumReq  request valid
- req_ready_o  out  NumReq  request accepted
- rsp_data_o  out  NumReq x CsrDataWidth  read data
- rsp_valid_o  out  NumReq  read response valid
- rsp_ready_i  in  NumReq  requester takes response
- csr_req_data_o  out  CsrDataWidth  to CSR
- csr_req_addr_o  out  CsrAddrWidth  to CSR
- csr_req_write_o  out  1  to CSR
- csr_req_valid_o  out  1  to CSR
- csr_req_ready_i  in  1  from CSR
- csr_rsp_data_i  in  CsrDataWidth  from CSR
- csr_rsp_valid_i  in  1  from CSR
- csr_rsp_ready_o  out  1  to CSR
- busy_o  out  1  read outstanding
- err_o  out  1  sticky: response received with no read outstanding

Behaviour:
Interface and state:
- One clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Registered state and reset values: state_q=IDLE, rr_ptr_q=0, owner_q=0, lock_q=0, lock_id_q=0, err_q=0.
- All other outputs are combinational from this state and the inputs.
- With all req_valid_i=0 after reset, every output is 0 except csr_rsp_ready_o=1.

Grant selection (IDLE):
- If lock_q=1, grant=lock_id_q.
- Otherwise grant is the first i with req_valid_i[i]=1, searching from rr_ptr_q upward modulo NumReq.
- If any requester is valid: csr_req_valid_o=1 and csr_req_data/addr/write_o = granted requester's fields; otherwise these outputs are 0.
- req_ready_o[grant]=csr_req_ready_i; all other req_ready_o=0.
- Accept occurs when csr_req_valid_o & csr_req_ready_i. On accept:
  - rr_ptr_q <= (grant+1) mod NumReq.
  - lock_q <= 0.
  - Write: stay in IDLE; the next request can be accepted the following cycle.
  - Read: owner_q <= grant, state -> WAIT_RSP.
- Valid but not accepted: lock_q <= 1, lock_id_q <= grant. The grant holds until accepted; a higher-priority arrival cannot preempt.
- Requesters hold valid and fields stable until ready. Dropping valid while locked is a protocol violation; the lock clears when no requester is valid.

WAIT_RSP:
- csr_req_valid_o=0 and all req_ready_o=0.
- rsp_valid_o[owner_q]=csr_rsp_valid_i and rsp_data_o[owner_q]=csr_rsp_data_i; other lanes valid=0, data=0.
- csr_rsp_ready_o=rsp_ready_i[owner_q].
- On response handshake -> IDLE. No new grant in the handshake cycle, so there is one bubble.
- busy_o=1 in WAIT_RSP.

Response in IDLE (spurious):
- csr_rsp_ready_o=1 in IDLE, so a stray response is drained and dropped.
- If csr_rsp_valid_i=1 in IDLE, err_q <= 1. err_o=err_q, cleared only by reset.

Latency and throughput:
- Request path is zero-latency combinational.
- Read round trip against a CSR with one-cycle response: accept at cycle N, response at N+1, next grant at N+2.
- Back-to-back writes: one per cycle.

Reset mid-operation:
- Reset in WAIT_RSP returns to IDLE immediately; the pending response lane is dropped.
- A response the CSR still presents after reset sets err_o.

Test Plan:
- Reset, no traffic -> all req_ready_o=0, csr_req_valid_o=0, busy_o=0, err_o=0, csr_rsp_ready_o=1.
- NumReq=3, all three write addr 0x1 with data 0xA/0xB/0xC continuously -> grants 0,1,2,0 on consecutive cycles; CSR sees 0xA,0xB,0xC.
- Req0 reads addr 0x2 while req1 holds a write pending -> req0 accepted at N; req1 ready stays 0 through N+1; rsp_valid_o[0] with CSR data at N+1; req1 accepted at N+2.
- Read with rsp_ready_i[owner]=0 for 5 cycles -> rsp_valid_o and data held stable, busy_o=1, no grants; release -> IDLE next cycle.
- csr_req_ready_i=0 with req1 granted, then req0 raises valid -> grant stays on req1 until ready=1.
- Inject csr_rsp_valid_i=1 in IDLE -> err_o=1 next cycle and stays 1 until rst_ni low; assert rst_ni in WAIT_RSP -> busy_o=0 immediately.
